multicycle_sequencer: RTL and testbench

Multicycle control FSM for the LEGv8 core. It sequences one instruction at a time through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a single shared instruction/data memory port. It takes the decoded control bits produced from the instruction register and turns them into per-phase write strobes and memory handshakes. It also provides a retired-instruction counter, a memory-wait timeout fault, and halt/resume.

---
 rtl/multicycle_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM for the LEGv8 core: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// over one shared memory port, with retire counting, memory-wait timeout fault and halt/resume.
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctl_memread,
    input  logic               ctl_memwrite,
    input  logic               ctl_regwrite,
    input  logic               ctl_ubranch,
    input  logic               ctl_link,
    input  logic               ctl_cbranch,
    input  logic               branch_taken,
    input  logic               mem_ready,
    input  logic               halt_req,
    input  logic               resume,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_addr_sel,
    output logic               ir_we,
    output logic               pc_we,
    output logic               pc_src,
    output logic               opr_we,
    output logic               alu_we,
    output logic               mdr_we,
    output logic               reg_we,
    output logic               retire,
    output logic               halted,
    output logic               fault,
    output logic [2:0]         state,
    output logic [COUNT_W-1:0] retired_count
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StHalt      = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                fault_q, fault_d;
    logic [COUNT_W-1:0]  count_q;

    // Decoded control bits captured in DECODE; later phases never look at the live ctl_* inputs.
    logic lat_memread_q, lat_memread_d;
    logic lat_memwrite_q, lat_memwrite_d;
    logic lat_regwrite_q, lat_regwrite_d;
    logic lat_ubranch_q, lat_ubranch_d;
    logic lat_link_q, lat_link_d;
    logic lat_cbranch_q, lat_cbranch_d;

    // Ungated strobes; the outputs are these masked by reset.
    logic mem_req_raw;
    logic mem_we_raw;
    logic ir_we_raw;
    logic pc_we_raw;
    logic opr_we_raw;
    logic alu_we_raw;
    logic mdr_we_raw;
    logic reg_we_raw;
    logic retire_raw;

    logic wait_expired;

    assign wait_expired = (wait_q == WAIT_LAST);

    always_comb begin
        state_d        = state_q;
        wait_d         = '0;
        fault_d        = fault_q;
        lat_memread_d  = lat_memread_q;
        lat_memwrite_d = lat_memwrite_q;
        lat_regwrite_d = lat_regwrite_q;
        lat_ubranch_d  = lat_ubranch_q;
        lat_link_d     = lat_link_q;
        lat_cbranch_d  = lat_cbranch_q;
        mem_req_raw    = 1'b0;
        mem_we_raw     = 1'b0;
        mem_addr_sel   = 1'b0;
        ir_we_raw      = 1'b0;
        pc_we_raw      = 1'b0;
        pc_src         = 1'b0;
        opr_we_raw     = 1'b0;
        alu_we_raw     = 1'b0;
        mdr_we_raw     = 1'b0;
        reg_we_raw     = 1'b0;
        retire_raw     = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req_raw = 1'b1;
                if (mem_ready) begin
                    ir_we_raw = 1'b1;
                    pc_we_raw = 1'b1;
                    state_d   = StDecode;
                end else if (wait_expired) begin
                    fault_d = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StDecode: begin
                opr_we_raw     = 1'b1;
                lat_memread_d  = ctl_memread;
                lat_memwrite_d = ctl_memwrite;
                lat_regwrite_d = ctl_regwrite;
                lat_ubranch_d  = ctl_ubranch;
                lat_link_d     = ctl_link;
                lat_cbranch_d  = ctl_cbranch;
                state_d        = halt_req ? StHalt : StExecute;
            end

            StExecute: begin
                alu_we_raw = 1'b1;
                if (lat_ubranch_q) begin
                    pc_we_raw  = 1'b1;
                    pc_src     = 1'b1;
                    if (lat_link_q) begin
                        state_d = StWriteback;
                    end else begin
                        retire_raw = 1'b1;
                        state_d    = StFetch;
                    end
                end else if (lat_cbranch_q) begin
                    pc_we_raw  = branch_taken;
                    pc_src     = 1'b1;
                    retire_raw = 1'b1;
                    state_d    = StFetch;
                end else if (lat_memread_q || lat_memwrite_q) begin
                    state_d = StMemory;
                end else if (lat_regwrite_q) begin
                    state_d = StWriteback;
                end else begin
                    retire_raw = 1'b1;
                    state_d    = StFetch;
                end
            end

            StMemory: begin
                mem_req_raw  = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we_raw   = lat_memwrite_q;
                if (mem_ready) begin
                    if (lat_memread_q) begin
                        mdr_we_raw = 1'b1;
                        state_d    = StWriteback;
                    end else begin
                        retire_raw = 1'b1;
                        state_d    = StFetch;
                    end
                end else if (wait_expired) begin
                    fault_d = 1'b1;
                    state_d = StHalt;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StWriteback: begin
                reg_we_raw = 1'b1;
                retire_raw = 1'b1;
                state_d    = StFetch;
            end

            StHalt: begin
                if (resume) begin
                    fault_d = 1'b0;
                    state_d = StFetch;
                end
            end

            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StFetch;
            wait_q         <= '0;
            fault_q        <= 1'b0;
            count_q        <= '0;
            lat_memread_q  <= 1'b0;
            lat_memwrite_q <= 1'b0;
            lat_regwrite_q <= 1'b0;
            lat_ubranch_q  <= 1'b0;
            lat_link_q     <= 1'b0;
            lat_cbranch_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_q         <= wait_d;
            fault_q        <= fault_d;
            lat_memread_q  <= lat_memread_d;
            lat_memwrite_q <= lat_memwrite_d;
            lat_regwrite_q <= lat_regwrite_d;
            lat_ubranch_q  <= lat_ubranch_d;
            lat_link_q     <= lat_link_d;
            lat_cbranch_q  <= lat_cbranch_d;
            if (retire_raw) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Strobes drop in the same cycle rst rises so an abandoned instruction writes nothing.
    assign mem_req       = mem_req_raw & ~rst;
    assign mem_we        = mem_we_raw & ~rst;
    assign ir_we         = ir_we_raw & ~rst;
    assign pc_we         = pc_we_raw & ~rst;
    assign opr_we        = opr_we_raw & ~rst;
    assign alu_we        = alu_we_raw & ~rst;
    assign mdr_we        = mdr_we_raw & ~rst;
    assign reg_we        = reg_we_raw & ~rst;
    assign retire        = retire_raw & ~rst;
    assign halted        = (state_q == StHalt);
    assign fault         = fault_q;
    assign state         = state_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: each instruction is scored against per-class
// expectations (latency, strobe counts, retire count) derived from the instruction's kind.
module tb_multicycle_sequencer;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 4;

    localparam int K_ALU = 0;
    localparam int K_LD  = 1;
    localparam int K_ST  = 2;
    localparam int K_CBT = 3;
    localparam int K_CBN = 4;
    localparam int K_B   = 5;
    localparam int K_BL  = 6;
    localparam int K_NOP = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          ctl_memread, ctl_memwrite, ctl_regwrite, ctl_ubranch, ctl_link, ctl_cbranch;
    logic          branch_taken, mem_ready, halt_req, resume;
    logic          mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, opr_we, alu_we;
    logic          mdr_we, reg_we, retire, halted, fault;
    logic [2:0]    state;
    logic [CW-1:0] retired_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    multicycle_sequencer #(
        .TIMEOUT(T),
        .COUNT_W(CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctl_memread  (ctl_memread),
        .ctl_memwrite (ctl_memwrite),
        .ctl_regwrite (ctl_regwrite),
        .ctl_ubranch  (ctl_ubranch),
        .ctl_link     (ctl_link),
        .ctl_cbranch  (ctl_cbranch),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .opr_we       (opr_we),
        .alu_we       (alu_we),
        .mdr_we       (mdr_we),
        .reg_we       (reg_we),
        .retire       (retire),
        .halted       (halted),
        .fault        (fault),
        .state        (state),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic logic rbit();
        return ($urandom() & 32'd1) != 32'd0;
    endfunction

    function automatic logic [31:0] strobes();
        return 32'({mem_req, mem_we, ir_we, pc_we, opr_we, alu_we, mdr_we, reg_we, retire});
    endfunction

    task automatic garbage_ctl();
        ctl_memread  = rbit();
        ctl_memwrite = rbit();
        ctl_regwrite = rbit();
        ctl_ubranch  = rbit();
        ctl_link     = rbit();
        ctl_cbranch  = rbit();
    endtask

    // Build a control word for a class; bits of lower priority than the deciding one are random.
    task automatic drive_ctl(input int k);
        ctl_link     = rbit();
        ctl_ubranch  = 1'b0;
        ctl_cbranch  = 1'b0;
        ctl_memread  = 1'b0;
        ctl_memwrite = 1'b0;
        ctl_regwrite = 1'b0;
        case (k)
            K_B, K_BL: begin
                ctl_ubranch  = 1'b1;
                ctl_link     = (k == K_BL);
                ctl_cbranch  = rbit();
                ctl_memread  = rbit();
                ctl_regwrite = rbit();
            end
            K_CBT, K_CBN: begin
                ctl_cbranch  = 1'b1;
                ctl_memwrite = rbit();
                ctl_regwrite = rbit();
            end
            K_LD: begin
                ctl_memread  = 1'b1;
                ctl_regwrite = rbit();
            end
            K_ST: begin
                ctl_memwrite = 1'b1;
                ctl_regwrite = rbit();
            end
            K_ALU: ctl_regwrite = 1'b1;
            default: ;
        endcase
    endtask

    // fw/mw: wait cycles before mem_ready in FETCH/MEMORY; >= T means never ready.
    task automatic run_instr(input int k, input int fw, input int mw, input bit do_halt);
        bit is_mem    = (k == K_LD) || (k == K_ST);
        bit exp_fault = (fw >= int'(T)) || (is_mem && mw >= int'(T));
        bit branchy   = (k == K_B) || (k == K_BL) || (k == K_CBT);
        bit writes    = (k == K_ALU) || (k == K_LD) || (k == K_BL);
        int base_lat;
        int cyc = 0, waited = 0, ret_at = -1;
        int n_req = 0, n_ir = 0, n_pc0 = 0, n_pc1 = 0, n_opr = 0, n_alu = 0;
        int n_mdr = 0, n_reg = 0, n_we = 0, n_ret = 0;
        case (k)
            K_LD:                 base_lat = 5;
            K_ALU, K_ST, K_BL:    base_lat = 4;
            default:              base_lat = 3;
        endcase
        check_eq("start_state", 32'(state), 0);
        while (cyc < 30 && !halted) begin
            if (cyc == fw + 1) begin
                drive_ctl(k);
                halt_req = do_halt;
            end else begin
                garbage_ctl();
                halt_req = rbit();
            end
            branch_taken = (cyc == fw + 2) ? (k == K_CBT) : rbit();
            resume = rbit();
            #1;
            if (mem_req) mem_ready = (waited == (mem_addr_sel ? mw : fw));
            else         mem_ready = rbit();
            #1;
            if (mem_req) begin
                n_req++;
                waited = mem_ready ? 0 : waited + 1;
            end
            if (mem_we)            n_we++;
            if (ir_we)             n_ir++;
            if (pc_we && !pc_src)  n_pc0++;
            if (pc_we && pc_src)   n_pc1++;
            if (opr_we)            n_opr++;
            if (alu_we)            n_alu++;
            if (mdr_we)            n_mdr++;
            if (reg_we)            n_reg++;
            if (retire) begin
                n_ret++;
                ret_at = cyc;
            end
            @(negedge clk);
            cyc++;
            if (ret_at >= 0) break;
        end
        if (exp_fault) begin
            check_eq("flt_fault", 32'(fault), 1);
            check_eq("flt_halted", 32'(halted), 1);
            check_eq("flt_retire", n_ret, 0);
            check_eq("flt_mdr", n_mdr, 0);
            check_eq("flt_req", n_req, (fw >= int'(T)) ? int'(T) : fw + 1 + int'(T));
            check_eq("flt_ir", n_ir, (fw >= int'(T)) ? 0 : 1);
        end else if (do_halt) begin
            check_eq("hlt_halted", 32'(halted), 1);
            check_eq("hlt_fault", 32'(fault), 0);
            check_eq("hlt_cycles", cyc, fw + 2);
            check_eq("hlt_retire", n_ret, 0);
            check_eq("hlt_alu", n_alu, 0);
        end else begin
            exp_cnt = (exp_cnt + 1) % (1 << CW);
            check_eq($sformatf("lat_k%0d", k), ret_at + 1, base_lat + fw + (is_mem ? mw : 0));
            check_eq("retire_n", n_ret, 1);
            check_eq("ir_n", n_ir, 1);
            check_eq("pc_seq_n", n_pc0, 1);
            check_eq($sformatf("pc_br_k%0d", k), n_pc1, branchy ? 1 : 0);
            check_eq("opr_n", n_opr, 1);
            check_eq("alu_n", n_alu, 1);
            check_eq("mdr_n", n_mdr, (k == K_LD) ? 1 : 0);
            check_eq($sformatf("reg_k%0d", k), n_reg, writes ? 1 : 0);
            check_eq("memwe_n", n_we, (k == K_ST) ? mw + 1 : 0);
            check_eq("memreq_n", n_req, fw + 1 + (is_mem ? mw + 1 : 0));
            check_eq("end_state", 32'(state), 0);
        end
        check_eq("count", 32'(retired_count), exp_cnt);
    endtask

    task automatic do_resume(input bit exp_fault);
        resume = 1'b0;
        for (int i = 0; i < 3; i++) begin
            halt_req  = rbit();
            mem_ready = rbit();
            garbage_ctl();
            #2;
            check_eq("halt_quiet", strobes(), 0);
            @(negedge clk);
            check_eq("halt_hold", 32'(halted), 1);
            check_eq("halt_fault", 32'(fault), 32'(exp_fault));
        end
        resume   = 1'b1;
        halt_req = rbit();
        @(negedge clk);
        resume = 1'b0;
        check_eq("resume_state", 32'(state), 0);
        check_eq("resume_fault", 32'(fault), 0);
        check_eq("resume_count", 32'(retired_count), exp_cnt);
    endtask

    task automatic reset_mid_mem();
        ctl_memread  = 1'b1;
        ctl_memwrite = 1'b0;
        ctl_regwrite = 1'b0;
        ctl_ubranch  = 1'b0;
        ctl_cbranch  = 1'b0;
        ctl_link     = 1'b0;
        halt_req     = 1'b0;
        resume       = 1'b0;
        mem_ready    = 1'b1;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check_eq("rmm_state", 32'(state), 3);
        check_eq("rmm_req", 32'(mem_req), 1);
        check_eq("rmm_sel", 32'(mem_addr_sel), 1);
        rst = 1'b1;
        #1;
        check_eq("rmm_strobes", strobes(), 0);
        @(negedge clk);
        check_eq("rmm_state0", 32'(state), 0);
        check_eq("rmm_count0", 32'(retired_count), 0);
        rst     = 1'b0;
        exp_cnt = 0;
    endtask

    initial begin
        int k, fw, mw;
        rst          = 1'b1;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;
        halt_req     = 1'b0;
        resume       = 1'b0;
        garbage_ctl();
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_strobes", strobes(), 0);
        check_eq("rst_state", 32'(state), 0);
        check_eq("rst_count", 32'(retired_count), 0);
        check_eq("rst_fault", 32'(fault), 0);
        check_eq("rst_halted", 32'(halted), 0);
        @(negedge clk);
        rst = 1'b0;

        run_instr(K_ALU, 0, 0, 1'b0);
        run_instr(K_LD, 0, 2, 1'b0);
        run_instr(K_ST, 0, 0, 1'b0);
        run_instr(K_CBT, 0, 0, 1'b0);
        run_instr(K_CBN, 0, 0, 1'b0);
        run_instr(K_B, 0, 0, 1'b0);
        run_instr(K_BL, 0, 0, 1'b0);
        run_instr(K_NOP, 0, 0, 1'b0);
        // Ready arriving in the last allowed wait cycle must beat the timeout.
        run_instr(K_LD, int'(T) - 1, int'(T) - 1, 1'b0);
        run_instr(K_ALU, 99, 0, 1'b0);
        do_resume(1'b1);
        run_instr(K_ST, 0, 99, 1'b0);
        do_resume(1'b1);
        run_instr(K_ALU, 1, 0, 1'b1);
        do_resume(1'b0);

        for (int i = 0; i < 60; i++) begin
            k  = int'($urandom_range(0, 7));
            fw = int'($urandom_range(0, T - 1));
            mw = int'($urandom_range(0, T - 1));
            run_instr(k, fw, mw, 1'b0);
        end

        reset_mid_mem();
        for (int i = 0; i < 20; i++) begin
            k  = int'($urandom_range(0, 7));
            fw = int'($urandom_range(0, 1));
            mw = int'($urandom_range(0, 1));
            run_instr(k, fw, mw, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
